// File: rtl/layer_compositor_pipe.sv
// layer_compositor_pipe
// Two-stage pipelined N-layer pixel compositor. The highest-index opaque
// layer wins; bg_color_i fills the pixel when no layer is opaque.
// Stage 1 registers the layer pixels and per-layer opacity, and stage 2
// registers the priority-encoded result. Flow control uses a combinational
// valid/ready chain. sof/eol tags travel alongside the pixel.
// Optional feature macro: COMPOSER_COLORKEY_EN. When it is defined, the
// key_color_i port sets the transparency key. When it is not defined, the key
// is black.
module layer_compositor_pipe #(
    parameter  int N  = 3,
    parameter  int CW = 8,
    localparam int PW = 3 * CW,
    localparam int LW = $clog2(N + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic [N-1:0][PW-1:0]  rgb_i,
    input  logic [N-1:0]          layer_en_i,
    input  logic                  sof_i,
    input  logic                  eol_i,
    input  logic [PW-1:0]         bg_color_i,
`ifdef COMPOSER_COLORKEY_EN
    input  logic [PW-1:0]         key_color_i,
`endif
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [PW-1:0]         rgb_o,
    output logic [LW-1:0]         layer_o,
    output logic                  sof_o,
    output logic                  eol_o
);

    // Flow control
    logic adv1_s;
    logic adv2_s;
    logic load_s1_s;
    logic load_s2_s;

    // Transparency key and per-layer opacity of the incoming pixel set
    logic [PW-1:0] key_s;
    logic [N-1:0]  opaque_s;

    // Stage 1 state
    logic                 s1_valid_d, s1_valid_q;
    logic [N-1:0][PW-1:0] s1_rgb_d,   s1_rgb_q;
    logic [N-1:0]         s1_opaque_d, s1_opaque_q;
    logic                 s1_sof_d,   s1_sof_q;
    logic                 s1_eol_d,   s1_eol_q;

    // Priority-encoder result on the stage 1 contents
    logic [PW-1:0] win_rgb_s;
    logic [LW-1:0] win_layer_s;

    // Stage 2 state (drives the outputs directly)
    logic          s2_valid_d, s2_valid_q;
    logic [PW-1:0] s2_rgb_d,   s2_rgb_q;
    logic [LW-1:0] s2_layer_d, s2_layer_q;
    logic          s2_sof_d,   s2_sof_q;
    logic          s2_eol_d,   s2_eol_q;

`ifdef COMPOSER_COLORKEY_EN
    assign key_s = key_color_i;
`else
    assign key_s = {PW{1'b0}};
`endif

    // Ready chain: a stage can advance when it is empty or when the stage after it drains
    always_comb begin
        adv2_s    = ~s2_valid_q | out_ready_i;
        adv1_s    = ~s1_valid_q | adv2_s;
        load_s1_s = adv1_s & in_valid_i;
        load_s2_s = adv2_s & s1_valid_q;
    end

    assign in_ready_o = adv1_s;

    // A layer is opaque when it is enabled and its pixel differs from the key
    always_comb begin
        opaque_s = {N{1'b0}};
        for (int k = 0; k < N; k++) begin
            opaque_s[k] = layer_en_i[k] & (rgb_i[k] != key_s);
        end
    end

    // Stage 1 next state: capture the input set on transfer, and drop to a bubble when idle
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_rgb_d    = s1_rgb_q;
        s1_opaque_d = s1_opaque_q;
        s1_sof_d    = s1_sof_q;
        s1_eol_d    = s1_eol_q;
        if (adv1_s) begin
            s1_valid_d = in_valid_i;
        end else begin
            s1_valid_d = s1_valid_q;
        end
        if (load_s1_s) begin
            s1_rgb_d    = rgb_i;
            s1_opaque_d = opaque_s;
            s1_sof_d    = sof_i;
            s1_eol_d    = eol_i;
        end else begin
            s1_rgb_d    = s1_rgb_q;
            s1_opaque_d = s1_opaque_q;
            s1_sof_d    = s1_sof_q;
            s1_eol_d    = s1_eol_q;
        end
    end

    // Priority select: scanning upward lets a higher opaque layer override a lower one
    always_comb begin
        win_rgb_s   = bg_color_i;
        win_layer_s = LW'(N);
        for (int k = 0; k < N; k++) begin
            win_rgb_s   = s1_opaque_q[k] ? s1_rgb_q[k] : win_rgb_s;
            win_layer_s = s1_opaque_q[k] ? LW'(k)      : win_layer_s;
        end
    end

    // Stage 2 next state: take the composed pixel when it can advance, and clear on a bubble
    always_comb begin
        s2_valid_d = s2_valid_q;
        s2_rgb_d   = s2_rgb_q;
        s2_layer_d = s2_layer_q;
        s2_sof_d   = s2_sof_q;
        s2_eol_d   = s2_eol_q;
        if (adv2_s) begin
            s2_valid_d = s1_valid_q;
        end else begin
            s2_valid_d = s2_valid_q;
        end
        if (load_s2_s) begin
            s2_rgb_d   = win_rgb_s;
            s2_layer_d = win_layer_s;
            s2_sof_d   = s1_sof_q;
            s2_eol_d   = s1_eol_q;
        end else begin
            s2_rgb_d   = s2_rgb_q;
            s2_layer_d = s2_layer_q;
            s2_sof_d   = s2_sof_q;
            s2_eol_d   = s2_eol_q;
        end
    end

    // Pipeline registers: reset discards any in-flight pixels
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1_valid_q  <= 1'b0;
            s1_rgb_q    <= {(N*PW){1'b0}};
            s1_opaque_q <= {N{1'b0}};
            s1_sof_q    <= 1'b0;
            s1_eol_q    <= 1'b0;
            s2_valid_q  <= 1'b0;
            s2_rgb_q    <= {PW{1'b0}};
            s2_layer_q  <= {LW{1'b0}};
            s2_sof_q    <= 1'b0;
            s2_eol_q    <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_rgb_q    <= s1_rgb_d;
            s1_opaque_q <= s1_opaque_d;
            s1_sof_q    <= s1_sof_d;
            s1_eol_q    <= s1_eol_d;
            s2_valid_q  <= s2_valid_d;
            s2_rgb_q    <= s2_rgb_d;
            s2_layer_q  <= s2_layer_d;
            s2_sof_q    <= s2_sof_d;
            s2_eol_q    <= s2_eol_d;
        end
    end

    assign out_valid_o = s2_valid_q;
    assign rgb_o       = s2_rgb_q;
    assign layer_o     = s2_layer_q;
    assign sof_o       = s2_sof_q;
    assign eol_o       = s2_eol_q;

endmodule

// File: tb/tb_layer_compositor_pipe.sv
// Self-checking bench for layer_compositor_pipe (N=3, CW=8).
// The reference model computes each expected output pixel when its input
// transfer happens and queues it. Output transfers pop the queue in order.
module tb_layer_compositor_pipe;

    localparam int N  = 3;
    localparam int CW = 8;
    localparam int PW = 3 * CW;
    localparam int LW = 2;

    logic                 clk = 1'b0;
    logic                 rst_ni;
    logic                 in_valid;
    logic                 out_ready;
    logic [N-1:0][PW-1:0] rgb;
    logic [N-1:0]         en;
    logic                 sof;
    logic                 eol;
    logic [PW-1:0]        bg;
    logic [PW-1:0]        key;

    logic                 in_ready_o;
    logic                 out_valid_o;
    logic [PW-1:0]        rgb_o;
    logic [LW-1:0]        layer_o;
    logic                 sof_o;
    logic                 eol_o;

    always #5 clk = ~clk;

    layer_compositor_pipe #(.N(N), .CW(CW)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready_o),
        .rgb_i       (rgb),
        .layer_en_i  (en),
        .sof_i       (sof),
        .eol_i       (eol),
        .bg_color_i  (bg),
`ifdef COMPOSER_COLORKEY_EN
        .key_color_i (key),
`endif
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready),
        .rgb_o       (rgb_o),
        .layer_o     (layer_o),
        .sof_o       (sof_o),
        .eol_o       (eol_o)
    );

    typedef struct packed {
        logic [PW-1:0] pix;
        logic [LW-1:0] layer;
        logic          sof;
        logic          eol;
    } exp_t;

    exp_t q[$];
    int   push_cyc[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   last_lat;
    int   out_cnt = 0;
    bit   ready_seen;
    bit   held_valid = 1'b0;
    exp_t held;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Reference rule: search layers from the top down. The first enabled
    // layer whose pixel is not the key wins. Otherwise the background wins.
    function automatic exp_t model(input logic [N-1:0][PW-1:0] p, input logic [N-1:0] e,
                                   input logic [PW-1:0] b, input logic [PW-1:0] k,
                                   input logic s, input logic l);
        exp_t r;
        r.sof = s;
        r.eol = l;
        for (int i = N - 1; i >= 0; i--) begin
            if (e[i] && p[i] != k) begin
                r.pix   = p[i];
                r.layer = LW'(i);
                return r;
            end
        end
        r.pix   = b;
        r.layer = LW'(N);
        return r;
    endfunction

    // One clock: sample at negedge, update scoreboard, return to posedge+1
    task automatic step(output bit acc);
        exp_t e;
        @(negedge clk);
        cyc++;
        if (held_valid) begin
            check("stall_valid", out_valid_o, 1);
            check("stall_rgb",   rgb_o,   held.pix);
            check("stall_layer", layer_o, held.layer);
            check("stall_sof",   sof_o,   held.sof);
            check("stall_eol",   eol_o,   held.eol);
        end
        if (out_valid_o && out_ready) begin
            if (q.size() == 0) begin
                check("unexpected_out", out_valid_o, 0);
            end else begin
                e = q.pop_front();
                last_lat = cyc - push_cyc.pop_front();
                out_cnt++;
                check("out_rgb",   rgb_o,   e.pix);
                check("out_layer", layer_o, e.layer);
                check("out_sof",   sof_o,   e.sof);
                check("out_eol",   eol_o,   e.eol);
            end
        end
        ready_seen = in_ready_o;
        acc = in_valid && in_ready_o;
        if (acc) begin
            q.push_back(model(rgb, en, bg, key, sof, eol));
            push_cyc.push_back(cyc);
        end
        held_valid = out_valid_o && !out_ready;
        held = '{pix: rgb_o, layer: layer_o, sof: sof_o, eol: eol_o};
        @(posedge clk);
        #1;
    endtask

    // Send one pixel set into an empty pipe and check that it emerges after 2 clocks
    task automatic send_single(input string tag);
        bit acc;
        last_lat = -1;
        in_valid = 1'b1;
        step(acc);
        check({tag, "_accept"}, acc, 1);
        in_valid = 1'b0;
        repeat (3) step(acc);
        check({tag, "_latency"}, last_lat, 2);
        check({tag, "_drained"}, q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int idx;
        int c;
        int n0;

        rst_ni    = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        rgb       = {(N*PW){1'b0}};
        en        = {N{1'b0}};
        sof       = 1'b0;
        eol       = 1'b0;
        bg        = 24'h000000;
        key       = 24'h000000;

        // 1. reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", out_valid_o, 0);
        check("rst_rgb",       rgb_o, 0);
        check("rst_layer",     layer_o, 0);
        check("rst_sof",       sof_o, 0);
        check("rst_eol",       eol_o, 0);
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        @(negedge clk);
        check("rst_in_ready",   in_ready_o, 1);
        check("rst_out_valid2", out_valid_o, 0);
        @(posedge clk);
        #1;

        // 2. highest opaque layer wins (L2 is black, so it is transparent by default)
        rgb = {24'h000000, 24'h333333, 24'h222222};
        en  = 3'b111;
        send_single("basic");

        // 3. background fill, then a disabled top layer
        bg  = 24'h0000FF;
        rgb = {24'h000000, 24'h000000, 24'h000000};
        en  = 3'b111;
        send_single("bg_fill");
        check("bg_fill_layer", layer_o, 3);
        rgb = {24'h555555, 24'h444444, 24'h000000};
        en  = 3'b011;
        send_single("disabled_top");
        check("disabled_top_rgb", rgb_o, 24'h444444);

        // 4. six-pixel stream with a 3-clock downstream stall
        n0  = out_cnt;
        idx = 0;
        c   = 0;
        while (idx < 6 && c < 40) begin
            out_ready = !(c >= 2 && c < 5);
            in_valid  = 1'b1;
            rgb = {24'hA00000 + 24'(idx), 24'hB00000 + 24'(idx), 24'hC00000 + 24'(idx)};
            en  = 3'(idx + 1);
            sof = (idx == 0);
            eol = (idx == 5);
            step(acc);
            if (c == 3) begin
                check("stall_in_ready", ready_seen, 0);
            end
            if (acc) begin
                idx++;
            end
            c++;
        end
        check("stream_all_sent", idx, 6);
        in_valid  = 1'b0;
        sof       = 1'b0;
        eol       = 1'b0;
        out_ready = 1'b1;
        repeat (4) step(acc);
        check("stream_count", out_cnt - n0, 6);
        check("stream_drained", q.size(), 0);

        // 5. reset with two pixels in flight
        rgb      = {24'h111111, 24'h000000, 24'h000000};
        en       = 3'b100;
        in_valid = 1'b1;
        step(acc);
        rgb = {24'h000000, 24'h000000, 24'h999999};
        en  = 3'b001;
        step(acc);
        in_valid = 1'b0;
        rst_ni   = 1'b0;
        #1;
        check("midrst_out_valid", out_valid_o, 0);
        check("midrst_rgb",       rgb_o, 0);
        q.delete();
        push_cyc.delete();
        held_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        repeat (4) step(acc);
        check("midrst_no_stale", out_valid_o, 0);

`ifdef COMPOSER_COLORKEY_EN
        // 6. colour key: the key colour is transparent and black is opaque
        key = 24'hFF00FF;
        rgb = {24'hFF00FF, 24'h000000, 24'h123456};
        en  = 3'b111;
        send_single("ckey");
        check("ckey_rgb",   rgb_o, 24'h000000);
        check("ckey_layer", layer_o, 1);
`endif

        // Random traffic with random backpressure
        bg = 24'($urandom);
        for (int i = 0; i < 300; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < N; k++) begin
                rgb[k] = ($urandom_range(0, 3) == 0) ? key : 24'($urandom);
            end
            en  = 3'($urandom);
            sof = 1'($urandom);
            eol = 1'($urandom);
            step(acc);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        c = 0;
        while ((q.size() != 0 || out_valid_o) && c < 10) begin
            step(acc);
            c++;
        end
        check("random_drained", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
